find_winner_nodes: RTL
======================

// Module: find_winner_nodes
// PURPOSE
//  Stage directly upstream of the winner weight/threshold update stage.
//  Scans the node store for the current input X and computes the squared Euclidean distance to each node.
//  Tracks the nearest node (s1) and second-nearest node (s2).
//  On completion, presents Ws1, Ws2, Ths1, Ms1 and min1_ED, which the update stage consumes directly.
// PARAMETERS
//  MAX_NODES  64                   capacity of node store; num_nodes range 0..MAX_NODES
//  IDX_W      $clog2(MAX_NODES)    node index/address width
// PORTS
//  clk         in   1                  single clock, rising edge
//  rst_n       in   1                  asynchronous, active-low reset
//  start       in   1                  begin scan; accepted only in IDLE
//  X_in        in   node_vector_T      input vector; sampled on the accepted start edge
//  num_nodes   in   IDX_W+1            number of live nodes; sampled with start
//  node_rd_en  out  1                  node store read strobe
//  node_rd_addr out IDX_W              node store read address
//  node_W      in   node_vector_T      node weights; valid 1 cycle after rd_en
//  node_Th     in   int                node threshold; same timing as node_W
//  node_M      in   int                node win count; same timing as node_W
//  busy        out  1                  high from accepted start until done
//  done        out  1                  one-cycle pulse; results valid from this cycle until next start
//  s1_valid    out  1                  at least one node scanned
//  s2_valid    out  1                  at least two nodes scanned
//  s1_idx, s2_idx  out  IDX_W          winner / runner-up indices
//  Ws1_out, Ws2_out  out node_vector_T weights of s1 / s2
//  Ths1_out, Ms1_out out int           Th and M of s1
//  min1_ED, min2_ED  out int           squared distances of s1 / s2
// BEHAVIOUR
//  - Reset: all outputs 0; min1_ED and min2_ED = 32'h7FFF_FFFF; FSM to IDLE.
//    Reset mid-scan aborts the scan with no done pulse.
//  - FSM states IDLE -> SCAN -> DRAIN -> DONE -> IDLE.
//    - start in IDLE: latch X_in and num_nodes; clear minima to 32'h7FFF_FFFF; clear valids; go to SCAN.
//      If num_nodes==0, go straight to DONE.
//    - SCAN: node_rd_en=1; node_rd_addr steps 0..num_nodes-1, one per cycle, no gaps.
//      After the last address, go to DRAIN.
//    - DRAIN: wait for the last read data (and pipeline stage, if enabled), then go to DONE.
//    - DONE: done=1 for one cycle, busy=0, return to IDLE.
//  - start while busy is ignored. A start in the DONE cycle is also ignored.
//  - Distance per element: d_i = {1'b0,X}-{1'b0,W} as a 9-bit signed value; square into 17-bit unsigned.
//    Sum over VECTOR_LEN into an int. No saturation is needed for VECTOR_LEN <= 1024.
//  - Update on each returned node (index k, distance d):
//    - d < min1: min2<=min1, s2<=s1 (with its W); min1<=d, s1<=k (capture W, Th, M).
//    - else if d < min2: min2<=d, s2<=k (capture W).
//    - Compares are strict: on a tie the lower index keeps its place.
//  - Valids: s1_valid is set on the first update; s2_valid is set on the second node scanned.
//    num_nodes==1 gives done with s2_valid=0, s2 fields 0, and min2_ED=7FFF_FFFF.
//  - Latency: done is high in the cycle after clock edge N+2, counting the start edge as edge 0
//    (N = num_nodes). With num_nodes==0, done follows start by 1 cycle.
//  - num_nodes > MAX_NODES is clamped to MAX_NODES.
// CONFIGURATION
//  FIND_WINNER_ED_PIPE_EN
//   - defined: a register is inserted between the squaring and the summation.
//     DRAIN lasts one extra cycle; done comes at edge N+3.
//   - undefined: squaring and summation are combinational; done comes at edge N+2.
//   - Results are identical in both cases.
// STRUCTURE
//  - GAM_package: node_vector_T and VECTOR_LEN (existing); ED_MAX constant (32'h7FFF_FFFF);
//    fwn_state_T enum {IDLE,SCAN,DRAIN,DONE}.
//  - One sub-module: squared_distance (node_vector_T a,b -> int ed).
//    Purely combinational; uses subtraction_signed per element.
//  - The FSM, address counter and min tracking stay in find_winner_nodes.
// TESTING (X all bytes 10 unless stated; memory model with 1-cycle read latency)
//  1. Nodes {all 20, all 12, all 11}, N=3
//     -> s1=2, min1_ED=VECTOR_LEN; s2=1, min2_ED=4*VECTOR_LEN; done at edge 5 (6 with PIPE_EN).
//  2. Tie: nodes {all 12, all 8}
//     -> s1=0, s2=1, min1_ED=min2_ED=4*VECTOR_LEN.
//  3. N=1 with node all 10 -> s1_valid=1, min1_ED=0, s2_valid=0, min2_ED=7FFF_FFFF.
//     N=0 -> done at edge 1, both valids 0.
//  4. Extremes: X all 0, node all 255
//     -> min1_ED=65025*VECTOR_LEN, with no sign or overflow error.
//  5. start pulsed while busy -> ignored: the address sequence is unbroken and only one done pulse occurs.
//  6. rst_n low during SCAN at address 1
//     -> outputs go to reset values at once, there is no done, and the next start scans cleanly.

Source files
------------

// File: rtl/find_winner_nodes_pkg.sv
// Shared types, constants and per-element distance helpers for the winner search.
package GAM_package;

    localparam int VECTOR_LEN = 4;

    typedef logic [VECTOR_LEN-1:0][7:0] node_vector_T;

    localparam int ED_MAX = 32'h7FFF_FFFF;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SCAN  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } fwn_state_T;

    // Zero-extend both bytes so the difference spans -255..255 without wrapping.
    function automatic logic signed [8:0] subtraction_signed(input logic [7:0] a, input logic [7:0] b);
        return $signed({1'b0, a}) - $signed({1'b0, b});
    endfunction

    function automatic logic [16:0] square_diff(input logic signed [8:0] d);
        logic signed [17:0] p;
        p = d * d;
        return p[16:0];
    endfunction

endpackage

// File: rtl/find_winner_nodes_squared_distance.sv
// Combinational squared Euclidean distance between two node vectors.
module squared_distance
    import GAM_package::*;
(
    input  node_vector_T a,
    input  node_vector_T b,
    output int           ed
);

    // Sum of per-element squares; fits an int for VECTOR_LEN up to 1024.
    always_comb begin
        ed = 0;
        for (int i = 0; i < VECTOR_LEN; i++) begin
            ed = ed + int'(square_diff(subtraction_signed(a[i], b[i])));
        end
    end

endmodule

// File: rtl/find_winner_nodes.sv
// Scans the node store and tracks nearest (s1) and second-nearest (s2) nodes to X.
// Optional macro FIND_WINNER_ED_PIPE_EN registers the distance before the min tracking.
module find_winner_nodes
    import GAM_package::*;
#(
    parameter int MAX_NODES = 64,
    parameter int IDX_W     = $clog2(MAX_NODES)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  node_vector_T     X_in,
    input  logic [IDX_W:0]   num_nodes,
    output logic             node_rd_en,
    output logic [IDX_W-1:0] node_rd_addr,
    input  node_vector_T     node_W,
    input  int               node_Th,
    input  int               node_M,
    output logic             busy,
    output logic             done,
    output logic             s1_valid,
    output logic             s2_valid,
    output logic [IDX_W-1:0] s1_idx,
    output logic [IDX_W-1:0] s2_idx,
    output node_vector_T     Ws1_out,
    output node_vector_T     Ws2_out,
    output int               Ths1_out,
    output int               Ms1_out,
    output int               min1_ED,
    output int               min2_ED
);

    fwn_state_T       state_r;
    node_vector_T     x_r;
    logic [IDX_W:0]   nn_r;
    logic [IDX_W:0]   nn_s;
    logic             drain_cnt_r;
    logic             rd_vld_r;
    logic [IDX_W-1:0] rd_idx_r;
    int               ed_s;

    logic             stg_vld_s;
    logic [IDX_W-1:0] stg_idx_s;
    int               stg_ed_s;
    node_vector_T     stg_w_s;
    int               stg_th_s;
    int               stg_m_s;

    assign nn_s = (num_nodes > (IDX_W+1)'(MAX_NODES)) ? (IDX_W+1)'(MAX_NODES) : num_nodes;

    squared_distance u_sqd (
        .a  (x_r),
        .b  (node_W),
        .ed (ed_s)
    );

    // Read data returns one cycle after the strobe; remember which index it belongs to.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_vld_r <= 1'b0;
            rd_idx_r <= '0;
        end else begin
            rd_vld_r <= node_rd_en;
            rd_idx_r <= node_rd_addr;
        end
    end

`ifdef FIND_WINNER_ED_PIPE_EN
    localparam logic DRAIN_EXTRA = 1'b1;

    logic             p_vld_r;
    logic [IDX_W-1:0] p_idx_r;
    int               p_ed_r;
    node_vector_T     p_w_r;
    int               p_th_r;
    int               p_m_r;

    // Distance register stage; carries the node's fields alongside its distance.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p_vld_r <= 1'b0;
            p_idx_r <= '0;
            p_ed_r  <= 32'sd0;
            p_w_r   <= '0;
            p_th_r  <= 32'sd0;
            p_m_r   <= 32'sd0;
        end else begin
            p_vld_r <= rd_vld_r;
            p_idx_r <= rd_idx_r;
            p_ed_r  <= ed_s;
            p_w_r   <= node_W;
            p_th_r  <= node_Th;
            p_m_r   <= node_M;
        end
    end

    assign stg_vld_s = p_vld_r;
    assign stg_idx_s = p_idx_r;
    assign stg_ed_s  = p_ed_r;
    assign stg_w_s   = p_w_r;
    assign stg_th_s  = p_th_r;
    assign stg_m_s   = p_m_r;
`else
    localparam logic DRAIN_EXTRA = 1'b0;

    assign stg_vld_s = rd_vld_r;
    assign stg_idx_s = rd_idx_r;
    assign stg_ed_s  = ed_s;
    assign stg_w_s   = node_W;
    assign stg_th_s  = node_Th;
    assign stg_m_s   = node_M;
`endif

    // Control FSM, address sequencing and nearest/runner-up tracking.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= IDLE;
            x_r          <= '0;
            nn_r         <= '0;
            drain_cnt_r  <= 1'b0;
            node_rd_en   <= 1'b0;
            node_rd_addr <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            s1_valid     <= 1'b0;
            s2_valid     <= 1'b0;
            s1_idx       <= '0;
            s2_idx       <= '0;
            Ws1_out      <= '0;
            Ws2_out      <= '0;
            Ths1_out     <= 32'sd0;
            Ms1_out      <= 32'sd0;
            min1_ED      <= ED_MAX;
            min2_ED      <= ED_MAX;
        end else begin
            done <= 1'b0;
            case (state_r)
                IDLE: begin
                    // The done cycle is spent in IDLE, so a start seen there must be rejected too.
                    if (start && !done) begin
                        x_r          <= X_in;
                        nn_r         <= nn_s;
                        busy         <= 1'b1;
                        node_rd_addr <= '0;
                        s1_valid     <= 1'b0;
                        s2_valid     <= 1'b0;
                        s1_idx       <= '0;
                        s2_idx       <= '0;
                        Ws1_out      <= '0;
                        Ws2_out      <= '0;
                        Ths1_out     <= 32'sd0;
                        Ms1_out      <= 32'sd0;
                        min1_ED      <= ED_MAX;
                        min2_ED      <= ED_MAX;
                        if (nn_s == '0) begin
                            state_r <= DONE;
                        end else begin
                            state_r    <= SCAN;
                            node_rd_en <= 1'b1;
                        end
                    end
                end
                SCAN: begin
                    if ({1'b0, node_rd_addr} == nn_r - (IDX_W+1)'(1)) begin
                        node_rd_en  <= 1'b0;
                        drain_cnt_r <= DRAIN_EXTRA;
                        state_r     <= DRAIN;
                    end else begin
                        node_rd_addr <= node_rd_addr + IDX_W'(1);
                    end
                end
                DRAIN: begin
                    if (drain_cnt_r == 1'b0) begin
                        state_r <= DONE;
                    end else begin
                        drain_cnt_r <= 1'b0;
                    end
                end
                DONE: begin
                    done    <= 1'b1;
                    busy    <= 1'b0;
                    state_r <= IDLE;
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase

            // Strict compares keep the lower index in place on a tie.
            if (stg_vld_s) begin
                s1_valid <= 1'b1;
                s2_valid <= s1_valid;
                if (stg_ed_s < min1_ED) begin
                    min2_ED  <= min1_ED;
                    s2_idx   <= s1_idx;
                    Ws2_out  <= Ws1_out;
                    min1_ED  <= stg_ed_s;
                    s1_idx   <= stg_idx_s;
                    Ws1_out  <= stg_w_s;
                    Ths1_out <= stg_th_s;
                    Ms1_out  <= stg_m_s;
                end else if (stg_ed_s < min2_ED) begin
                    min2_ED <= stg_ed_s;
                    s2_idx  <= stg_idx_s;
                    Ws2_out <= stg_w_s;
                end
            end
        end
    end

endmodule
